reset_btn_ctrl: RTL and testbench
=================================

# reset_btn_ctrl

Parametrised board-level reset sequencer and button conditioner for the ULX3S top. It sits between the ecp5pll lock outputs and on-board buttons on one side, and `soc_top.reset_i` and soc GPIO/LED logic on the other. It replaces the direct combinational lock/button reset with synchronised, debounced, stretched reset. It provides per-button debounced state, press/release pulses and optional long-press detection.

## Interface
Parameters:
- `NUM_BTNS`, 7: number of raw buttons.
- `BTN_POL`, 7'b0000001: per-button polarity; bit set = active-low raw input.
- `NUM_LOCKS`, 2: number of PLL lock inputs.
- `RESET_BTN`, 0: index of the button that forces system reset.
- `DEBOUNCE_CYCLES`, 400_000: stable cycles required before a button changes state; ≥2.
- `RESET_HOLD_CYCLES`, 65_536: reset stretch after locks are good; ≥1.
- `LONG_PRESS_CYCLES`, 40_000_000: held cycles before the long-press pulse; > `DEBOUNCE_CYCLES`.

Ports:
- `clk_i`  in  1  single clock (cpu clock domain).
- `reset_n_i`  in  1  synchronous, active-low reset.
- `locked_i`  in  NUM_LOCKS  raw PLL lock bits, asynchronous to `clk_i`.
- `btn_i`  in  NUM_BTNS  raw buttons, asynchronous.
- `btn_o`  out  NUM_BTNS  debounced pressed state, 1 = pressed.
- `press_o`  out  NUM_BTNS  one-cycle pulse on debounced press.
- `release_o`  out  NUM_BTNS  one-cycle pulse on debounced release.
- `long_o`  out  NUM_BTNS  one-cycle long-press pulse (zero when `LONG_PRESS_EN` is undefined).
- `reset_o`  out  1  active-high system reset to `soc_top.reset_i`.
- `ready_o`  out  1  high only in RUN.

## Operation
- Reset while `reset_n_i`=0 at a clock edge: `btn_o`, `press_o`, `release_o`, `long_o` = 0; `reset_o`=1; `ready_o`=0; FSM in WAIT_LOCK; all counters 0.
- Reset values of the synchronisers: button stages = `BTN_POL`, so the normalised value is "released"; lock stages = 0.
- Every `btn_i` and `locked_i` bit passes through a 2-flop synchroniser. Normalised pressed value `p[i] = sync[i] ^ BTN_POL[i]`.
- Debounce, per button, with a counter of width `$clog2(DEBOUNCE_CYCLES+1)`:
  - If `p[i] == btn_o[i]`, the counter clears.
  - Otherwise the counter increments.
  - On the cycle the counter equals `DEBOUNCE_CYCLES-1` while still differing, `btn_o[i]` toggles, the counter clears, and `press_o[i]` (0→1) or `release_o[i]` (1→0) is high for that one cycle, aligned with the `btn_o` change.
- Reset FSM. `all_lock` = AND of synchronised locks. `rb` = `btn_o[RESET_BTN]`.
  - WAIT_LOCK: `reset_o`=1. If `all_lock & ~rb`, go to STRETCH with the hold counter at 0.
  - STRETCH: `reset_o`=1; the counter increments. If `~all_lock | rb`, go to WAIT_LOCK. Otherwise, when the counter equals `RESET_HOLD_CYCLES-1`, go to RUN.
  - RUN: `reset_o`=0, `ready_o`=1. If `~all_lock | rb`, go to WAIT_LOCK.
  - The fault check has priority over the terminal count in the same cycle.
- `reset_o` and `ready_o` are registered and decoded from the state register.
- Debounce and long-press logic keep running in every FSM state; only `reset_n_i` clears them.
- A reset-button press is debounced before it affects reset, so glitches shorter than `DEBOUNCE_CYCLES` never reset the soc.

## Timing
- Raw button edge to `btn_o`: 2 sync cycles + `DEBOUNCE_CYCLES`, with +1 cycle of sampling uncertainty.
- Bounce: any return to `p==btn_o` restarts the count from 0.
- Synchronised `all_lock` rising at cycle t: STRETCH at t+1; `reset_o` falls at t+1+`RESET_HOLD_CYCLES`.
- Lock drop: raw edge to `reset_o`=1 in at most 3 cycles (2 sync + 1 FSM).
- `rb` rising at cycle t: `reset_o`=1 at t+1.
- Re-entry after a fault: the full `RESET_HOLD_CYCLES` stretch is always applied again; there is no partial credit.

## Configuration
- Macro: `LONG_PRESS_EN`.
- Defined: each button has a saturating counter of width `$clog2(LONG_PRESS_CYCLES+1)`.
  - The counter clears when `btn_o[i]`=0 and increments while `btn_o[i]`=1.
  - `long_o[i]` pulses one cycle when the count reaches `LONG_PRESS_CYCLES-1`; the counter then saturates, so there is one pulse per press.
  - Count starts on the cycle after `press_o`.
- Undefined: no counters are generated; `long_o` is tied to 0.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `RESET_HOLD_CYCLES`=8, `LONG_PRESS_CYCLES`=16, `NUM_LOCKS`=2.
- Power-up: `reset_n_i`=0 for 3 cycles, locks=2'b11 → all outputs at reset values; after release, `reset_o` falls exactly 2+1+8 cycles after `reset_n_i` rises.
- Bounce: `btn_i[1]` toggles 1-high/1-low five times then holds high → exactly one `press_o[1]` pulse, 2+4 cycles after the final rise; no `release_o`.
- Lock drop in RUN: `locked_i[1]`=0 for 1 cycle → `reset_o`=1 within 3 cycles; after re-lock, `reset_o` stays high for the full 8-cycle stretch.
- Reset button (`btn_i[0]` low, active-low): 3-cycle glitch → `reset_o` stays 0; 10-cycle press → `reset_o`=1 one cycle after `btn_o[0]` rises, held until release + debounce + 8.
- Long press with `LONG_PRESS_EN`: hold `btn_i[2]` for 40 cycles → `long_o[2]` pulses once, 16 cycles after `press_o[2]`. Without the macro, `long_o` stays 0.
- Simultaneous events: `rb` rises on the STRETCH terminal-count cycle → FSM goes to WAIT_LOCK, `ready_o` never asserts.

Source files
------------

// File: rtl/reset_btn_ctrl_if.sv
// Button/lock/reset bundle between reset_btn_ctrl and the board top.
// slave = controller side, master = board/soc side.
interface reset_btn_ctrl_if #(
  parameter int unsigned NUM_BTNS  = 7,
  parameter int unsigned NUM_LOCKS = 2
);
  logic [NUM_LOCKS-1:0] locked_i;
  logic [NUM_BTNS-1:0]  btn_i;
  logic [NUM_BTNS-1:0]  btn_o;
  logic [NUM_BTNS-1:0]  press_o;
  logic [NUM_BTNS-1:0]  release_o;
  logic [NUM_BTNS-1:0]  long_o;
  logic                 reset_o;
  logic                 ready_o;

  modport slave (
    input  locked_i, btn_i,
    output btn_o, press_o, release_o, long_o, reset_o, ready_o
  );

  modport master (
    output locked_i, btn_i,
    input  btn_o, press_o, release_o, long_o, reset_o, ready_o
  );
endinterface

// File: rtl/reset_btn_ctrl.sv
// Board reset sequencer and button conditioner: synchronise, debounce, stretch.
// Optional long-press detection enabled by defining LONG_PRESS_EN.
module reset_btn_ctrl #(
  parameter int unsigned           NUM_BTNS          = 7,
  parameter logic [NUM_BTNS-1:0]   BTN_POL           = 7'b0000001,
  parameter int unsigned           NUM_LOCKS         = 2,
  parameter int unsigned           RESET_BTN         = 0,
  parameter int unsigned           DEBOUNCE_CYCLES   = 400_000,
  parameter int unsigned           RESET_HOLD_CYCLES = 65_536,
  parameter int unsigned           LONG_PRESS_CYCLES = 40_000_000
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  reset_btn_ctrl_if.slave   bus
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW  = $clog2(RESET_HOLD_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (RESET_HOLD_CYCLES < 1) begin : g_chk_hold
    $error("RESET_HOLD_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
    $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_STRETCH,
    ST_RUN
  } state_t;

  logic [NUM_BTNS-1:0]  r_btn_s1, r_btn_s2;
  logic [NUM_LOCKS-1:0] r_lock_s1, r_lock_s2;
  logic [NUM_BTNS-1:0]  r_btn, r_press, r_rel;
  logic [DBW-1:0]       r_db_cnt [NUM_BTNS];
  state_t               r_state;
  logic [HW-1:0]        r_hold;
  logic                 r_reset, r_ready;

  logic [NUM_BTNS-1:0]  w_pressed;
  logic                 w_fault;

  // Two-flop synchronisers; button stages reset to the "released" level
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_btn_s1  <= BTN_POL;
      r_btn_s2  <= BTN_POL;
      r_lock_s1 <= '0;
      r_lock_s2 <= '0;
    end else begin
      r_btn_s1  <= bus.btn_i;
      r_btn_s2  <= r_btn_s1;
      r_lock_s1 <= bus.locked_i;
      r_lock_s2 <= r_lock_s1;
    end
  end

  assign w_pressed = r_btn_s2 ^ BTN_POL;
  assign w_fault   = ~(&r_lock_s2) | r_btn[RESET_BTN];

  // Per-button debounce: any agreement with the current state restarts the count
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_btn   <= '0;
      r_press <= '0;
      r_rel   <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        r_press[i] <= 1'b0;
        r_rel[i]   <= 1'b0;
        if (w_pressed[i] == r_btn[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_btn[i]    <= w_pressed[i];
          r_press[i]  <= w_pressed[i];
          r_rel[i]    <= ~w_pressed[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Reset sequencer; a fault always wins over the stretch terminal count
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state <= ST_WAIT_LOCK;
      r_hold  <= '0;
      r_reset <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          if (!w_fault) begin
            r_state <= ST_STRETCH;
            r_hold  <= '0;
          end
        end
        ST_STRETCH: begin
          if (w_fault) begin
            r_state <= ST_WAIT_LOCK;
          end else if (r_hold == HW'(RESET_HOLD_CYCLES - 1)) begin
            r_state <= ST_RUN;
            r_reset <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        ST_RUN: begin
          if (w_fault) begin
            r_state <= ST_WAIT_LOCK;
            r_reset <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_WAIT_LOCK;
          r_reset <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES + 1);

  logic [LW-1:0]       r_lp_cnt [NUM_BTNS];
  logic [NUM_BTNS-1:0] r_long;

  // Saturating hold counter parks at LONG_PRESS_CYCLES so each press pulses once
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_long <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) r_lp_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        r_long[i] <= 1'b0;
        if (!r_btn[i]) begin
          r_lp_cnt[i] <= '0;
        end else if (r_lp_cnt[i] == LW'(LONG_PRESS_CYCLES - 1)) begin
          r_long[i]   <= 1'b1;
          r_lp_cnt[i] <= LW'(LONG_PRESS_CYCLES);
        end else if (r_lp_cnt[i] != LW'(LONG_PRESS_CYCLES)) begin
          r_lp_cnt[i] <= r_lp_cnt[i] + LW'(1);
        end
      end
    end
  end

  assign bus.long_o = r_long;
`else
  assign bus.long_o = '0;
`endif

  assign bus.btn_o     = r_btn;
  assign bus.press_o   = r_press;
  assign bus.release_o = r_rel;
  assign bus.reset_o   = r_reset;
  assign bus.ready_o   = r_ready;

endmodule

// File: tb/tb_reset_btn_ctrl.sv
// Self-checking bench for reset_btn_ctrl: directed timing scenarios plus random
// button/lock noise checked every cycle against a run-length behavioural model.
module tb_reset_btn_ctrl;

  localparam int unsigned NB  = 7;
  localparam int unsigned NL  = 2;
  localparam logic [NB-1:0] POL = 7'b0000001;
  localparam int unsigned RB  = 0;
  localparam int          DB  = 4;
  localparam int          HLD = 8;
  localparam int          LP  = 16;
`ifdef LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reset_btn_ctrl_if #(.NUM_BTNS(NB), .NUM_LOCKS(NL)) bus ();

  reset_btn_ctrl #(
    .NUM_BTNS(NB), .BTN_POL(POL), .NUM_LOCKS(NL), .RESET_BTN(RB),
    .DEBOUNCE_CYCLES(DB), .RESET_HOLD_CYCLES(HLD), .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Synchronisers are a 2-deep delay line; debounce is "D consecutive differing
  // samples"; the sequencer is "HLD+1 consecutive good cycles"; long press is
  // "LP consecutive cycles held".
  logic [NB-1:0] m_d1, m_d2, m_btn, m_press, m_rel, m_long;
  logic [NL-1:0] m_l1, m_l2;
  logic [NB-1:0] mp;
  logic          mg;
  int            m_dif [NB];
  int            m_held [NB];
  int            m_glen;
  logic          m_rst, m_rdy;
  bit            m_init = 1'b0;

  always @(posedge clk) begin
    m_init = 1'b1;
    if (!reset_n) begin
      m_d1 = POL; m_d2 = POL; m_l1 = '0; m_l2 = '0;
      m_btn = '0; m_press = '0; m_rel = '0; m_long = '0;
      m_glen = 0; m_rst = 1'b1; m_rdy = 1'b0;
      for (int i = 0; i < NB; i++) begin m_dif[i] = 0; m_held[i] = 0; end
    end else begin
      mp = m_d2 ^ POL;
      mg = (&m_l2) && !m_btn[RB];
      m_d2 = m_d1; m_d1 = bus.btn_i;
      m_l2 = m_l1; m_l1 = bus.locked_i;
      m_glen = mg ? ((m_glen < HLD + 1) ? m_glen + 1 : m_glen) : 0;
      m_rst = (m_glen < HLD + 1);
      m_rdy = !m_rst;
      for (int i = 0; i < NB; i++) begin
        m_held[i] = m_btn[i] ? ((m_held[i] <= LP) ? m_held[i] + 1 : m_held[i]) : 0;
        m_long[i] = LP_EN && (m_held[i] == LP);
        m_press[i] = 1'b0;
        m_rel[i]   = 1'b0;
        if (mp[i] != m_btn[i]) begin
          m_dif[i]++;
          if (m_dif[i] == DB) begin
            m_btn[i]   = mp[i];
            m_press[i] = mp[i];
            m_rel[i]   = !mp[i];
            m_dif[i]   = 0;
          end
        end else begin
          m_dif[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("btn_o",     32'(bus.btn_o),     32'(m_btn));
      chk("press_o",   32'(bus.press_o),   32'(m_press));
      chk("release_o", 32'(bus.release_o), 32'(m_rel));
      chk("long_o",    32'(bus.long_o),    32'(m_long));
      chk("reset_o",   32'(bus.reset_o),   32'(m_rst));
      chk("ready_o",   32'(bus.ready_o),   32'(m_rdy));
    end
  end

  // ---------------- stimulus-side event capture ----------------
  int cyc = 0;
  int pc [NB], rc [NB], lc [NB], press_cyc [NB], long_cyc [NB];
  int rst_rise_cyc, rst_fall_cyc, rst_rises, b0_rise_cyc, b0_fall_cyc, ready_hi;
  logic prev_rst = 1'b1;
  logic prev_b0  = 1'b0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NB; i++) begin
      if (bus.press_o[i])   begin pc[i]++; press_cyc[i] = cyc; end
      if (bus.release_o[i]) rc[i]++;
      if (bus.long_o[i])    begin lc[i]++; long_cyc[i] = cyc; end
    end
    if (bus.reset_o && !prev_rst) begin rst_rise_cyc = cyc; rst_rises++; end
    if (!bus.reset_o && prev_rst) rst_fall_cyc = cyc;
    if (bus.btn_o[RB] && !prev_b0) b0_rise_cyc = cyc;
    if (!bus.btn_o[RB] && prev_b0) b0_fall_cyc = cyc;
    if (bus.ready_o) ready_hi++;
    prev_rst = bus.reset_o;
    prev_b0  = bus.btn_o[RB];
  endtask

  int t0, n, p0, r0, l0, rr0;

  initial begin
    for (int i = 0; i < NB; i++) begin
      pc[i] = 0; rc[i] = 0; lc[i] = 0; press_cyc[i] = 0; long_cyc[i] = 0;
    end
    rst_rise_cyc = 0; rst_fall_cyc = 0; rst_rises = 0;
    b0_rise_cyc = 0; b0_fall_cyc = 0; ready_hi = 0;

    // Power-up
    reset_n = 1'b0;
    bus.locked_i = 2'b11;
    bus.btn_i = POL;
    repeat (3) tick();
    chk("rst_btn_o",   32'(bus.btn_o),     0);
    chk("rst_press",   32'(bus.press_o),   0);
    chk("rst_release", 32'(bus.release_o), 0);
    chk("rst_long",    32'(bus.long_o),    0);
    chk("rst_reset_o", 32'(bus.reset_o),   1);
    chk("rst_ready_o", 32'(bus.ready_o),   0);
    reset_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.reset_o && n < 50);
    chk("pwrup_latency", 32'(n), 11);
    chk("pwrup_ready", 32'(bus.ready_o), 1);

    // Bounce on btn[1]
    repeat (3) tick();
    p0 = pc[1]; r0 = rc[1];
    for (int k = 0; k < 5; k++) begin
      bus.btn_i[1] = 1'b1; tick();
      bus.btn_i[1] = 1'b0; tick();
    end
    bus.btn_i[1] = 1'b1;
    t0 = cyc;
    repeat (10) tick();
    chk("bounce_press_cnt", 32'(pc[1] - p0), 1);
    chk("bounce_release_cnt", 32'(rc[1] - r0), 0);
    chk("bounce_latency", 32'(press_cyc[1] - t0), 6);
    bus.btn_i[1] = 1'b0;
    repeat (10) tick();
    chk("bounce_released", 32'(rc[1] - r0), 1);

    // Lock drop in RUN
    chk("run_before_drop", 32'(bus.ready_o), 1);
    bus.locked_i[1] = 1'b0;
    t0 = cyc;
    tick();
    bus.locked_i[1] = 1'b1;
    repeat (20) tick();
    chk("lockdrop_latency", 32'(rst_rise_cyc - t0), 3);
    chk("relock_stretch", 32'(rst_fall_cyc - rst_rise_cyc), 9);

    // Reset button: short glitch then real press
    rr0 = rst_rises;
    bus.btn_i[0] = 1'b0;
    repeat (3) tick();
    bus.btn_i[0] = 1'b1;
    repeat (15) tick();
    chk("glitch_no_reset", 32'(rst_rises - rr0), 0);
    t0 = cyc;
    bus.btn_i[0] = 1'b0;
    repeat (10) tick();
    bus.btn_i[0] = 1'b1;
    repeat (30) tick();
    chk("rbtn_press_latency", 32'(b0_rise_cyc - t0), 6);
    chk("rbtn_reset_after_btn", 32'(rst_rise_cyc - b0_rise_cyc), 1);
    chk("rbtn_release_latency", 32'(b0_fall_cyc - t0), 16);
    chk("rbtn_reset_release", 32'(rst_fall_cyc - b0_fall_cyc), 9);

    // Long press on btn[2]
    l0 = lc[2]; p0 = pc[2];
    bus.btn_i[2] = 1'b1;
    repeat (40) tick();
    bus.btn_i[2] = 1'b0;
    repeat (10) tick();
    chk("long_press_cnt", 32'(pc[2] - p0), 1);
    if (LP_EN) begin
      chk("long_pulse_cnt", 32'(lc[2] - l0), 1);
      chk("long_latency", 32'(long_cyc[2] - press_cyc[2]), 16);
    end else begin
      chk("long_pulse_cnt", 32'(lc[2] - l0), 0);
    end

    // Reset button lands on the stretch terminal-count cycle
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    ready_hi = 0;
    t0 = cyc;
    repeat (4) tick();
    bus.btn_i[0] = 1'b0;
    repeat (10) tick();
    bus.btn_i[0] = 1'b1;
    repeat (8) tick();
    chk("simul_rb_cycle", 32'(b0_rise_cyc - t0), 10);
    chk("simul_no_ready", 32'(ready_hi), 0);
    n = 0;
    while (!bus.ready_o && n < 40) begin tick(); n++; end
    chk("simul_recovers", 32'(bus.ready_o), 1);

    // Random noise on buttons and locks
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        n = int'($urandom_range(0, NB - 1));
        bus.btn_i[n] = ~bus.btn_i[n];
      end
      if ($urandom_range(0, 99) == 0)
        bus.locked_i[$urandom_range(0, NL - 1)] = 1'b0;
      else if ($urandom_range(0, 7) == 0)
        bus.locked_i = 2'b11;
      tick();
    end
    bus.btn_i = POL;
    bus.locked_i = 2'b11;
    repeat (30) tick();
    chk("final_ready", 32'(bus.ready_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
